rounding_unit_normalizer: RTL
=============================

# rounding_unit_normalizer

Two-stage pipelined normalizer that sits directly upstream of the rounding unit's fraction incrementer. It takes the raw 49-bit fraction and biased exponent from the arithmetic datapath and produces a fraction in [xx.xxxx...] format with bit 47 as the leading one, plus the matching adjusted exponent and a sticky-preserving LSB. It has a valid/ready handshake so the rounding unit can stall it.

## Interface
- No parameters; widths fixed by the FPU datapath.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears pipeline.
- in_valid  input  1  input beat present.
- in_ready  output  1  normalizer accepts the beat this cycle.
- in_fraction  input  49  [xx.xxxx...], 2 integer bits, 47 fractional bits.
- in_exponent  input  10  signed biased exponent.
- out_valid  output  1  normalized beat present.
- out_ready  input  1  rounding unit consumes the beat this cycle.
- normalized_fraction  output  49  same format; bit 48 = 0, bit 47 = 1 unless zero or subnormal.
- out_exponent  output  10  signed biased exponent after adjustment.
- out_zero  output  1  input fraction was all zeros.

## Operation
- Stage 1 (S1) registers the input.
  - If in_fraction[48] = 1: pre-shift right by 1, with new bit 0 = fraction[1] | fraction[0] (sticky). Exponent +1. Leading-zero count (lzc) = 0.
  - Else: lzc = leading zeros of fraction[47:0], range 0..48.
  - S1 holds fraction, exponent, lzc and a zero flag (lzc = 48).
- Stage 2 (S2) registers the result.
  - Fraction = S1 fraction << shift, with zeros filled in. Exponent = S1 exponent − shift.
  - Zero case: fraction 0, exponent 0, out_zero = 1.
- Exponent arithmetic is 10-bit signed two's complement. Stage 1 +1 and stage 2 −shift are computed 11 bits wide, then truncated. Wrap-around is not flagged; the upstream range keeps |exponent| < 512.
- Handshake, elastic with no bubbles:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Transfers occur on in_valid & in_ready and on out_valid & out_ready.
  - A held output stays stable while out_valid & !out_ready.
- Simultaneous accept and consume: full throughput of 1 beat per cycle with both stages full.
- Reset mid-operation drops both in-flight beats. No beat is output after reset deasserts unless a new one is accepted.

## Timing
- Latency: 2 cycles. A beat accepted at edge N is visible on the outputs after edge N+1 (out_valid high in cycle N+2 relative to acceptance cycle N).
- Throughput: 1 per cycle.
- Reset values:
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - normalized_fraction = 0, out_exponent = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset.
- in_ready is combinational from out_ready and internal valids. out_* are registered only.

## Configuration
- RU_NORM_SUBNORMAL_CLAMP_EN defined:
  - shift = min(lzc, max(in_exponent_s1 − 1, 0)).
  - If shift < lzc, the result is subnormal: bit 47 = 0 is allowed and out_exponent = 0 (IEEE encoding; scale equals exponent 1).
  - Otherwise the exponent is S1 exponent − lzc.
- Undefined: shift = lzc always. out_exponent may be ≤ 0, and flush/denormal handling is left to downstream.

## Test plan
- Reset, then in_valid=1, fraction=49'h0_8000_0000_0000 (bit 47), exp=127 → after 2 cycles out_valid=1, fraction unchanged, exp=127, out_zero=0.
- fraction with bit 48 set and bits 1:0 = 2'b10, exp=100 → fraction[47]=1, bit 0 = 1 (sticky), exp=101.
- fraction=49'h1 (bit 0 only), exp=200 → fraction bit 47 only, exp=153. With the clamp macro, exp=20 gives shift=19, fraction=1<<19, exp=0.
- fraction=0, exp=55 → fraction=0, exp=0, out_zero=1.
- Stream 6 back-to-back beats with out_ready held low from cycle 3 to 6 → in_ready drops once both stages are full, and held outputs are stable. No beat is lost or duplicated, and order is preserved.
- Assert reset with both stages valid → next cycle out_valid=0, in_ready=1. The following accepted beat emerges with correct data 2 cycles later.

Source files
------------

// File: rtl/rounding_unit_normalizer.sv
// rounding_unit_normalizer
// Two-stage elastic normalizer in front of the rounding unit's fraction
// incrementer. Stage 1 pre-shifts an overflowed fraction (keeping a sticky
// LSB) and counts leading zeros. Stage 2 left-shifts so that bit 47 is the
// leading one and adjusts the exponent to match.
// Optional feature: define RU_NORM_SUBNORMAL_CLAMP_EN to limit the shift so
// the exponent never drops below 1. Results that would need a larger shift
// come out as subnormals with exponent 0.
module rounding_unit_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] in_fraction,
  input  logic [9:0]  in_exponent,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [48:0] normalized_fraction,
  output logic [9:0]  out_exponent,
  output logic        out_zero
);

  // Stage 1 state
  logic        s1_valid_reg;
  logic [48:0] s1_fraction_reg;
  logic [9:0]  s1_exponent_reg;
  logic [5:0]  s1_lzc_reg;
  logic        s1_zero_reg;

  // Stage 2 state (drives the outputs directly)
  logic        s2_valid_reg;
  logic [48:0] s2_fraction_reg;
  logic [9:0]  s2_exponent_reg;
  logic        s2_zero_reg;

  // Stage 1 next-state values
  logic [48:0] s1_fraction_next;
  logic [9:0]  s1_exponent_next;
  logic [5:0]  s1_lzc_next;
  logic [5:0]  pre_lzc;

  // Stage 2 next-state values
  logic [48:0] s2_fraction_next;
  logic [9:0]  s2_exponent_next;
  logic [5:0]  shift;
  logic        subnormal;

  logic s1_adv;
  logic s2_adv;

  // A stage may advance when it is empty or its downstream is advancing
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid           = s2_valid_reg;
  assign normalized_fraction = s2_fraction_reg;
  assign out_exponent        = s2_exponent_reg;
  assign out_zero            = s2_zero_reg;

  // Stage 1 combinational: overflow pre-shift or leading-zero count
  always_comb begin
    // Ascending scan: the highest set bit is the last one to write pre_lzc
    pre_lzc = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (in_fraction[i]) pre_lzc = 6'(47 - i);
    end
    if (in_fraction[48]) begin
      // Right shift by one, folding the dropped bit into the new LSB.
      // A 10-bit sum is the truncated 11-bit sum; overflow wraps silently.
      s1_fraction_next = {1'b0, in_fraction[48:2], in_fraction[1] | in_fraction[0]};
      s1_exponent_next = in_exponent + 10'd1;
      s1_lzc_next      = 6'd0;
    end else begin
      s1_fraction_next = in_fraction;
      s1_exponent_next = in_exponent;
      s1_lzc_next      = pre_lzc;
    end
  end

  // Stage 2 combinational: choose the shift, normalize, adjust exponent
  always_comb begin
`ifdef RU_NORM_SUBNORMAL_CLAMP_EN
    logic [10:0] exp_m1;
    // Largest shift that keeps the exponent at 1 or above
    exp_m1 = {s1_exponent_reg[9], s1_exponent_reg} - 11'd1;
    if (exp_m1[10]) begin
      shift = 6'd0;
    end else if (exp_m1 < {5'd0, s1_lzc_reg}) begin
      shift = exp_m1[5:0];
    end else begin
      shift = s1_lzc_reg;
    end
    subnormal = (shift != s1_lzc_reg);
`else
    shift     = s1_lzc_reg;
    subnormal = 1'b0;
`endif
    s2_fraction_next = s1_fraction_reg << shift;
    s2_exponent_next = s1_exponent_reg - {4'd0, shift};
    if (s1_zero_reg) begin
      s2_fraction_next = 49'd0;
      s2_exponent_next = 10'd0;
    end else if (subnormal) begin
      // Subnormal encoding: exponent field 0 scales the same as exponent 1
      s2_exponent_next = 10'd0;
    end
  end

  // Stage 1 register: accept a new beat whenever the stage can advance
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg    <= 1'b0;
      s1_fraction_reg <= 49'd0;
      s1_exponent_reg <= 10'd0;
      s1_lzc_reg      <= 6'd0;
      s1_zero_reg     <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_fraction_reg <= s1_fraction_next;
        s1_exponent_reg <= s1_exponent_next;
        s1_lzc_reg      <= s1_lzc_next;
        s1_zero_reg     <= (s1_lzc_next == 6'd48);
      end
    end
  end

  // Stage 2 register: output data holds while the rounding unit stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg    <= 1'b0;
      s2_fraction_reg <= 49'd0;
      s2_exponent_reg <= 10'd0;
      s2_zero_reg     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_fraction_reg <= s2_fraction_next;
        s2_exponent_reg <= s2_exponent_next;
        s2_zero_reg     <= s1_zero_reg;
      end
    end
  end

endmodule
